pwm_capture_avalon: RTL and testbench
=====================================

Name: pwm_capture_avalon

Overview:
- Receive-side counterpart of the servo PWM generator: measures the high time and period of an incoming PWM/pulse signal (servo feedback, encoder or sensor pulse) in clock cycles.
- Exposes the results to the soft processor through the same Avalon-MM slave style (cs/read/write/readdata) used by the servo peripheral.
- Sits on the Avalon bus beside the servo peripheral. Its pwm_in connects to a board pin or directly to another block's pwm_out.

Parameters:
- CNT_W, 32, width of the cycle counter and of the HIGH_TIME/PERIOD registers (8..32).
- TIMEOUT_CYCLES, 32'd1_000_000, cycles without an edge before TIMEOUT is flagged; must be < 2^CNT_W - 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset; all state clears immediately, release is synchronous to clk
- cs  input  1  chip select; read/write are ignored unless cs=1
- read  input  1  read strobe
- write  input  1  write strobe
- address  input  2  register select
- writedata  input  32  write data
- readdata  output  32  read data, registered
- pwm_in  input  1  asynchronous pulse input
- sample_irq  output  1  level interrupt = NEW & IRQ_EN

Behaviour:
- Register map (word address):
  - 0 HIGH_TIME (RO)
  - 1 PERIOD (RO)
  - 2 STATUS (RO): bit0 NEW, bit1 TIMEOUT, bit2 synced pwm level, other bits 0
  - 3 CTRL (RW): bit0 EN, bit1 IRQ_EN, other bits read 0
- Register values are zero-extended to 32 bits on readdata.
- Reset: readdata=0, sample_irq=0, HIGH_TIME=PERIOD=0, NEW=TIMEOUT=0, CTRL=0, FSM=DISABLED, counter=0, synchroniser flops=0.
- Read: cs&read at edge N puts the selected register on readdata at edge N+1 (fixed latency 1). readdata holds its value otherwise.
- Read side effects:
  - Reading address 1 (PERIOD) clears NEW.
  - Reading address 2 (STATUS) clears TIMEOUT. The value returned is the value before the clear.
- Write: cs&write to address 3 updates CTRL at the next edge. Writes to addresses 0-2 are ignored. When read and write are asserted together, both take effect.
- Input path: 2-flop synchroniser, then a previous-value flop. rise/fall are single-cycle pulses. Total pin-to-detect latency is 3 cycles, identical for both edges, so measured widths are exact for inputs stable at least 3 cycles.
- FSM:
  - DISABLED: counter held at 0. EN=1 -> WAIT_RISE.
  - WAIT_RISE: discards partial pulses. On rise: counter<=0, go HIGH.
  - HIGH: counter increments each cycle. On fall: hi_lat<=counter+1, go LOW.
  - LOW: counter increments. On rise: HIGH_TIME<=hi_lat, PERIOD<=counter+1, NEW<=1, counter<=0, go HIGH.
  - Any state except DISABLED, EN=0: go DISABLED next cycle. Measurement registers are retained.
  - Example: input high 3 cycles, low 5 cycles gives HIGH_TIME=3, PERIOD=8.
- Timeout: in HIGH or LOW, when the counter reaches TIMEOUT_CYCLES with no edge: TIMEOUT<=1, go WAIT_RISE. HIGH_TIME/PERIOD are unchanged. Covers stuck-high and stuck-low inputs.
- Counter saturates at 2^CNT_W-1 and never wraps.
- Simultaneous events:
  - Commit and a PERIOD read in the same cycle: readdata returns the old PERIOD, and NEW ends at 1 (set wins).
  - Timeout and a STATUS read in the same cycle: TIMEOUT ends at 1.
- Reset mid-pulse: everything clears. After release with EN=0, nothing measures until software sets EN.
- sample_irq is registered from the NEW and IRQ_EN flops, with no combinational path from the bus.

Decomposition:
- Shared package holds:
  - register address constants: ADDR_HIGH_TIME, ADDR_PERIOD, ADDR_STATUS, ADDR_CTRL
  - STATUS/CTRL bit-index constants
  - FSM state encoding: DISABLED, WAIT_RISE, HIGH, LOW
- One natural sub-module: pulse_edge_sync. It contains the 2-flop synchroniser plus previous-value flop and outputs level, rise and fall. The servo peripheral's pwm_response path can reuse it.

Test Plan:
- Reset value checks: reset_n=0 for 10 cycles, then read all 4 addresses -> readdata=0 each, sample_irq=0.
- Basic capture: write CTRL=3, drive pwm_in high 3 / low 5 for 4 periods. Read HIGH_TIME -> 3, PERIOD -> 8, STATUS bit0=1 before the PERIOD read, sample_irq=1 and clears after the PERIOD read.
- Duty change mid-stream: switch to high 5 / low 3 -> next committed values HIGH_TIME=5, PERIOD=8. Enable while pwm_in is high -> the first partial pulse is not reported.
- Timeout: TIMEOUT_CYCLES=20, hold pwm_in low 30 cycles after a rise/fall -> STATUS=0x2, HIGH_TIME/PERIOD unchanged. A STATUS read clears TIMEOUT, and the next read returns 0.
- Collision: issue a PERIOD read in the exact commit cycle -> readdata shows the old value and NEW remains 1. Write EN=0 mid-pulse -> no commit, and registers keep their last values.
- Async reset mid-measurement: pulse reset_n low for 2.3 time units during HIGH -> all registers 0 immediately, FSM DISABLED, no commit after release.

Source files
------------

// File: rtl/pwm_capture_avalon_pkg.sv
`timescale 1ns/1ps
// Purpose : shared register map, bit positions and FSM encoding for the PWM capture peripheral.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pwm_capture_avalon_pkg;

    // Word addresses on the Avalon-MM slave.
    localparam logic [1:0] ADDR_HIGH_TIME = 2'd0;
    localparam logic [1:0] ADDR_PERIOD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS    = 2'd2;
    localparam logic [1:0] ADDR_CTRL      = 2'd3;

    // STATUS bit positions.
    localparam int STATUS_NEW_BIT     = 0;
    localparam int STATUS_TIMEOUT_BIT = 1;
    localparam int STATUS_LEVEL_BIT   = 2;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_avalon_pulse_edge_sync.sv
`timescale 1ns/1ps
// Purpose : brings an asynchronous pulse into the clock domain and flags its edges.
// Latency : pin change to rise/fall pulse acted upon at the 3rd clock edge, same for both edges.
// Backpressure: none; free-running, rise/fall are single-cycle pulses.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input pin
//   level_o - synchronised level
//   rise_o  - one-cycle pulse on a synchronised 0->1 transition
//   fall_o  - one-cycle pulse on a synchronised 1->0 transition
module pwm_capture_avalon_pulse_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;   // first synchroniser stage, may go metastable
    logic sync_q;   // second synchroniser stage, safe to use
    logic prev_q;   // previous synchronised value for edge detection

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture_avalon.sv
`timescale 1ns/1ps
// Purpose : measures high time and period of an incoming PWM signal, exposed on an Avalon-MM slave.
// Latency : reads return on readdata one clock after cs&read; captures commit 3 cycles after the pin rises.
// Backpressure: none; the slave never stalls (no waitrequest), reads/writes complete in one cycle.
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   cs, read, write        - Avalon-MM strobes (ignored unless cs=1)
//   address, writedata     - register select and write data
//   readdata               - registered read data
//   pwm_in                 - asynchronous pulse input
//   sample_irq             - level interrupt, NEW & IRQ_EN
module pwm_capture_avalon
    import pwm_capture_avalon_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        pwm_in,
    output logic        sample_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_CNT  = TIMEOUT_CYCLES[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic pwm_level;
    logic pwm_rise;
    logic pwm_fall;

    pwm_capture_avalon_pulse_edge_sync u_edge_sync (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .d_i     (pwm_in),
        .level_o (pwm_level),
        .rise_o  (pwm_rise),
        .fall_o  (pwm_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cap_state_t       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] hi_lat_q,    hi_lat_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q,    period_d;
    logic             new_q,       new_d;
    logic             timeout_q,   timeout_d;
    logic             en_q,        en_d;
    logic             irq_en_q,    irq_en_d;
    logic [31:0]      readdata_q,  readdata_d;
    logic             irq_q;

    logic             bus_rd;
    logic             bus_wr;
    logic             commit;
    logic             timeout_evt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      ht_word;
    logic [31:0]      per_word;
    logic [31:0]      status_word;
    logic [31:0]      ctrl_word;

    // Only EN and IRQ_EN are writable; the remaining write bits have no home.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:2];

    assign bus_rd  = cs & read;
    assign bus_wr  = cs & write;
    // Saturating increment: a stuck counter is preferable to a wrapped one.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        commit      = 1'b0;
        timeout_evt = 1'b0;

        case (state_q)
            DISABLED: begin
                cnt_d = '0;
                if (en_q) begin
                    state_d = WAIT_RISE;
                end
            end

            // Whatever pulse was in flight at enable time is discarded;
            // measurement only starts on a clean rising edge.
            WAIT_RISE: begin
                cnt_d = '0;
                if (!en_q) begin
                    state_d = DISABLED;
                end else if (pwm_rise) begin
                    state_d = HIGH;
                end
            end

            HIGH: begin
                if (!en_q) begin
                    state_d = DISABLED;
                    cnt_d   = '0;
                end else if (pwm_fall) begin
                    // +1 accounts for the cycle in which the edge is seen.
                    hi_lat_d = cnt_inc;
                    cnt_d    = cnt_inc;
                    state_d  = LOW;
                end else if (cnt_q == TO_CNT) begin
                    timeout_evt = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_RISE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            LOW: begin
                if (!en_q) begin
                    state_d = DISABLED;
                    cnt_d   = '0;
                end else if (pwm_rise) begin
                    // Next period begins on this same edge.
                    commit      = 1'b1;
                    high_time_d = hi_lat_q;
                    period_d    = cnt_inc;
                    cnt_d       = '0;
                    state_d     = HIGH;
                end else if (cnt_q == TO_CNT) begin
                    timeout_evt = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_RISE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = DISABLED;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file, flags and read mux
    // ------------------------------------------------------------------
    always_comb begin
        ht_word                  = '0;
        ht_word[CNT_W-1:0]       = high_time_q;
        per_word                 = '0;
        per_word[CNT_W-1:0]      = period_q;
        status_word                     = '0;
        status_word[STATUS_NEW_BIT]     = new_q;
        status_word[STATUS_TIMEOUT_BIT] = timeout_q;
        status_word[STATUS_LEVEL_BIT]   = pwm_level;
        ctrl_word                  = '0;
        ctrl_word[CTRL_EN_BIT]     = en_q;
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
    end

    always_comb begin
        new_d      = new_q;
        timeout_d  = timeout_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        readdata_d = readdata_q;

        // Flags: read-clear first, so a same-cycle set overrides the clear.
        if (bus_rd && (address == ADDR_PERIOD)) begin
            new_d = 1'b0;
        end
        if (commit) begin
            new_d = 1'b1;
        end
        if (bus_rd && (address == ADDR_STATUS)) begin
            timeout_d = 1'b0;
        end
        if (timeout_evt) begin
            timeout_d = 1'b1;
        end

        if (bus_wr && (address == ADDR_CTRL)) begin
            en_d     = writedata[CTRL_EN_BIT];
            irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        end

        // Read data is taken from the current (pre-update) register values.
        if (bus_rd) begin
            case (address)
                ADDR_HIGH_TIME: readdata_d = ht_word;
                ADDR_PERIOD:    readdata_d = per_word;
                ADDR_STATUS:    readdata_d = status_word;
                default:        readdata_d = ctrl_word;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DISABLED;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            new_q       <= 1'b0;
            timeout_q   <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            new_q       <= new_d;
            timeout_q   <= timeout_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            readdata_q  <= readdata_d;
            // Tracks NEW & IRQ_EN cycle-for-cycle while still leaving the
            // pin driven straight from a flop.
            irq_q       <= new_d & irq_en_d;
        end
    end

    assign readdata   = readdata_q;
    assign sample_irq = irq_q;

endmodule

// File: tb/tb_pwm_capture_avalon.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for pwm_capture_avalon.
// Latency : n/a.
// Backpressure: n/a.
module tb_pwm_capture_avalon;
    import pwm_capture_avalon_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pwm_in;
    logic        sample_irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] e;

    pwm_capture_avalon #(
        .CNT_W          (32),
        .TIMEOUT_CYCLES (32'd20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_in     (pwm_in),
        .sample_irq (sample_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; address = a;
        @(posedge clk);
        #1;
        cs = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        cs = 1'b1; write = 1'b1; address = a; writedata = wd;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic pwm_pulses(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            cyc(hi);
            pwm_in = 1'b0;
            cyc(lo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = '0; pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++; $display("FAIL reset_readdata: got 0x%0h expected 0x0", readdata);
        end
        for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            e = exp_q.pop_front();
            total++;
            if (rd !== e) begin
                bad++; $display("FAIL reset_read addr%0d: got 0x%0h expected 0x%0h", a, rd, e);
            end
        end
        total++;
        if (sample_irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %b expected 0", sample_irq);
        end
    endtask

    task automatic test_basic();
        bus_write(ADDR_CTRL, 32'hFFFF_FFFF);
        exp_q.push_back(32'h3);
        bus_read(ADDR_CTRL, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL ctrl_readback: got 0x%0h expected 0x%0h", rd, e); end

        pwm_pulses(3, 5, 4);
        exp_q.push_back(32'h1);   // STATUS: NEW only
        exp_q.push_back(32'd3);   // HIGH_TIME
        exp_q.push_back(32'd3);   // HIGH_TIME after ignored write
        exp_q.push_back(32'd8);   // PERIOD

        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL basic_status: got 0x%0h expected 0x%0h", rd, e); end
        total++;
        if (sample_irq !== 1'b1) begin bad++; $display("FAIL basic_irq_set: got %b expected 1", sample_irq); end
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL basic_high_time: got %0d expected %0d", rd, e); end
        bus_write(ADDR_HIGH_TIME, 32'hFFFF_FFFF);
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL ro_write_ignored: got %0d expected %0d", rd, e); end
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL basic_period: got %0d expected %0d", rd, e); end
        cyc(1);
        total++;
        if (sample_irq !== 1'b0) begin bad++; $display("FAIL basic_irq_clear: got %b expected 0", sample_irq); end
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_duty_change();
        // Enable while the input is already high: that pulse must be dropped.
        pwm_in = 1'b1;
        cyc(4);
        bus_write(ADDR_CTRL, 32'h3);
        cyc(2);
        pwm_in = 1'b0;
        cyc(3);
        pwm_pulses(5, 3, 1);
        exp_q.push_back(32'h0);   // no commit yet after first full pulse
        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL partial_not_reported: got 0x%0h expected 0x%0h", rd, e); end

        pwm_pulses(5, 3, 2);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd8);
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL duty_high_time: got %0d expected %0d", rd, e); end
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL duty_period: got %0d expected %0d", rd, e); end
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_timeout();
        bus_write(ADDR_CTRL, 32'h1);
        pwm_pulses(4, 30, 1);
        exp_q.push_back(32'h2);   // TIMEOUT only
        exp_q.push_back(32'h0);   // cleared by the previous read
        exp_q.push_back(32'd5);   // unchanged
        exp_q.push_back(32'd8);   // unchanged
        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL timeout_status: got 0x%0h expected 0x%0h", rd, e); end
        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL timeout_cleared: got 0x%0h expected 0x%0h", rd, e); end
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL timeout_high_time: got %0d expected %0d", rd, e); end
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL timeout_period: got %0d expected %0d", rd, e); end
        total++;
        if (sample_irq !== 1'b0) begin bad++; $display("FAIL timeout_irq: got %b expected 0", sample_irq); end
    endtask

    task automatic test_collision();
        // FSM is in WAIT_RISE with EN=1. Pulse A: high 4, low 6; rise B commits.
        pwm_in = 1'b1;
        cyc(4);
        pwm_in = 1'b0;
        cyc(6);
        pwm_in = 1'b1;
        cyc(2);
        // This read is sampled on the same edge that commits HIGH_TIME=4/PERIOD=10.
        exp_q.push_back(32'd8);
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL collision_old_period: got %0d expected %0d", rd, e); end
        exp_q.push_back(32'h5);   // NEW survives the colliding read, level high
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd10);
        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL collision_new_kept: got 0x%0h expected 0x%0h", rd, e); end
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL collision_high_time: got %0d expected %0d", rd, e); end
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL collision_period: got %0d expected %0d", rd, e); end

        // Disable while still in the high phase; later edges must not commit.
        bus_write(ADDR_CTRL, 32'h0);
        pwm_in = 1'b0;
        cyc(4);
        pwm_in = 1'b1;
        cyc(4);
        pwm_in = 1'b0;
        cyc(4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd10);
        bus_read(ADDR_STATUS, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL disable_status: got 0x%0h expected 0x%0h", rd, e); end
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL disable_high_time: got %0d expected %0d", rd, e); end
        bus_read(ADDR_PERIOD, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL disable_period: got %0d expected %0d", rd, e); end
    endtask

    task automatic test_async_reset();
        bus_write(ADDR_CTRL, 32'h3);
        pwm_pulses(3, 5, 2);
        total++;
        if (sample_irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b expected 1", sample_irq); end
        exp_q.push_back(32'd3);
        bus_read(ADDR_HIGH_TIME, rd); e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL pre_reset_high_time: got %0d expected %0d", rd, e); end

        pwm_in = 1'b1;
        cyc(4);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL async_rst_readdata: got 0x%0h expected 0x0", readdata); end
        total++;
        if (sample_irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq: got %b expected 0", sample_irq); end
        #1.3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        pwm_in = 1'b0;
        cyc(5);
        pwm_pulses(3, 5, 2);
        for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            e = exp_q.pop_front();
            total++;
            if (rd !== e) begin
                bad++; $display("FAIL post_reset_read addr%0d: got 0x%0h expected 0x%0h", a, rd, e);
            end
        end
        total++;
        if (sample_irq !== 1'b0) begin bad++; $display("FAIL post_reset_irq: got %b expected 0", sample_irq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_timeout();
        test_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
